// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 18;
    localparam logic [1:0]  MEM_IO_PREFIX  = 2'b11;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_I    = 2'd1,
        SRC_D    = 2'd2
    } src_t;

endpackage : mem_pkg

// File: rtl/mem_ctrl.sv
// Arbitrates data-cache and instruction-cache byte requests onto a single-port
// RAM/IO bus; D has fixed priority and completions return one cycle after issue.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter logic [1:0]  IO_PREFIX  = MEM_IO_PREFIX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic                  io_buffer_full,
    input  logic                  d_req_en,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [7:0]            d_wdata,
    output logic                  d_out_en,
    output logic [7:0]            d_rdata,
    input  logic                  i_req_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_out_en,
    output logic [7:0]            i_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr
);

    src_t        sel_s;
    src_t        issued_q;
    logic [31:0] addr_q;
    logic        d_is_io_s;
    logic        d_stalled_s;
    logic [31:0] d_addr_ext_s;
    logic [31:0] i_addr_ext_s;

    assign d_is_io_s    = (d_addr[ADDR_WIDTH-1 -: 2] == IO_PREFIX);
    // An IO write that would overflow the UART buffer is held back without blocking I.
    assign d_stalled_s  = d_write & d_is_io_s & io_buffer_full;
    assign d_addr_ext_s = {{(32-ADDR_WIDTH){1'b0}}, d_addr};
    assign i_addr_ext_s = {{(32-ADDR_WIDTH){1'b0}}, i_addr};

    // Issue selection: at most one access per cycle, D first.
    always_comb begin
        sel_s = SRC_NONE;
        if (rst || !rdy_in) begin
            sel_s = SRC_NONE;
        end else if (d_req_en && !d_stalled_s) begin
            sel_s = SRC_D;
        end else if (i_req_en) begin
            sel_s = SRC_I;
        end else begin
            sel_s = SRC_NONE;
        end
    end

    // Bus drive for the selected source; idle cycles park on the last address.
    always_comb begin
        mem_a    = addr_q;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        if (rst) begin
            mem_a    = 32'h0000_0000;
            mem_wr   = 1'b0;
            mem_dout = 8'h00;
        end else begin
            case (sel_s)
                SRC_D: begin
                    mem_a    = d_addr_ext_s;
                    mem_wr   = d_write;
                    mem_dout = d_wdata;
                end
                SRC_I: begin
                    mem_a    = i_addr_ext_s;
                    mem_wr   = 1'b0;
                    mem_dout = 8'h00;
                end
                default: begin
                    mem_a    = addr_q;
                    mem_wr   = 1'b0;
                    mem_dout = 8'h00;
                end
            endcase
        end
    end

    // Issued-source and parked-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= SRC_NONE;
            addr_q   <= 32'h0000_0000;
        end else begin
            issued_q <= sel_s;
            if (sel_s != SRC_NONE) begin
                addr_q <= mem_a;
            end
        end
    end

    assign d_out_en = (issued_q == SRC_D);
    assign i_out_en = (issued_q == SRC_I);
    assign d_rdata  = mem_din;
    assign i_rdata  = mem_din;

endmodule : mem_ctrl
